// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC output path.
// Sample helpers work on 32-bit containers; callers slice to their bus width.
package dac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun
  } dac_state_e;

  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  // Two's complement to offset-binary is a flip of the sign bit.
  function automatic logic [31:0] to_offset_bin(input logic [31:0] sample, input logic twos,
                                                input int unsigned width);
    return twos ? (sample ^ midscale(width)) : sample;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output and synchronous flush.
// A word is readable at o_data from the cycle after its write; no write-to-read bypass.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW + 1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // Flush wins over both ports so a same-cycle write is dropped.
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dac_stream_out.sv
// Streaming DAC output stage: FIFO-buffered samples released every DIV_N sys_clk cycles,
// with a mid-sample dac_clk rise, prefill gate and underrun handling.
module dac_stream_out
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIV_N      = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PRIME_LVL  = 8,
  parameter int unsigned TWOS_IN    = 0
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          hold_on_underrun,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          dac_clk,
  output logic [DATA_W-1:0]             dac_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt
);

  localparam int unsigned CW = $clog2(DIV_N);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale(DATA_W));

  dac_state_e        r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_dac_clk, w_dac_clk_nxt;
  logic [DATA_W-1:0] r_dac_data, w_dac_data_nxt;
  logic [DATA_W-1:0] r_last, w_last_nxt;
  logic              r_underrun, w_underrun_nxt;
  logic [15:0]       r_underrun_cnt, w_underrun_cnt_nxt;

  logic              w_pop;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_fifo_data;
  logic [DATA_W-1:0] w_sample;
  logic [LW-1:0]     w_level;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst_n (rst_n),
    .i_flush (w_flush),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_sample = DATA_W'(to_offset_bin(32'(w_fifo_data), TWOS_IN != 0, DATA_W));

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_dac_data_nxt     = r_dac_data;
    w_last_nxt         = r_last;
    w_underrun_nxt     = 1'b0;
    w_underrun_cnt_nxt = r_underrun_cnt;
    w_pop              = 1'b0;
    w_flush            = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (enable) w_state_nxt = StPrime;
      end
      StPrime: begin
        if (!enable) begin
          w_flush        = 1'b1;
          w_state_nxt    = StIdle;
          w_dac_data_nxt = MIDSCALE;
        end else if (w_level >= LW'(PRIME_LVL)) begin
          w_state_nxt    = StRun;
          w_cnt_nxt      = '0;
          w_pop          = 1'b1;
          w_dac_data_nxt = w_sample;
          w_last_nxt     = w_sample;
        end
      end
      StRun: begin
        if (!enable) begin
          w_flush        = 1'b1;
          w_state_nxt    = StIdle;
          w_cnt_nxt      = '0;
          w_dac_data_nxt = MIDSCALE;
        end else if (r_cnt == CW'(DIV_N - 1)) begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_dac_data_nxt = w_sample;
            w_last_nxt     = w_sample;
          end else begin
            w_underrun_nxt = 1'b1;
            w_dac_data_nxt = hold_on_underrun ? r_last : MIDSCALE;
            if (r_underrun_cnt != 16'hFFFF) w_underrun_cnt_nxt = r_underrun_cnt + 16'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    // Low for the first DIV_N/2 counts so the rise lands mid-sample.
    w_dac_clk_nxt = (w_state_nxt == StRun) && (w_cnt_nxt >= CW'(DIV_N / 2));
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_dac_clk      <= 1'b0;
      r_dac_data     <= '0;
      r_last         <= '0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_dac_clk      <= w_dac_clk_nxt;
      r_dac_data     <= w_dac_data_nxt;
      r_last         <= w_last_nxt;
      r_underrun     <= w_underrun_nxt;
      r_underrun_cnt <= w_underrun_cnt_nxt;
    end
  end

  assign in_ready     = !w_full;
  assign dac_clk      = r_dac_clk;
  assign dac_data     = r_dac_data;
  assign fifo_level   = w_level;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_dac_stream_out.sv
// Directed bench for dac_stream_out: default build plus a two's-complement, DIV_N=5 build.
module tb_dac_stream_out;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enable, hold_on_underrun, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, dac_clk, underrun;
  logic [7:0]  dac_data;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_cnt;

  logic        tc_enable, tc_in_valid;
  logic [7:0]  tc_in_data;
  logic        tc_in_ready, tc_dac_clk, tc_underrun;
  logic [7:0]  tc_dac_data;
  logic [4:0]  tc_fifo_level;
  logic [15:0] tc_underrun_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int acc;

  always #5 sys_clk = ~sys_clk;

  dac_stream_out u_dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .hold_on_underrun (hold_on_underrun),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .dac_clk          (dac_clk),
    .dac_data         (dac_data),
    .fifo_level       (fifo_level),
    .underrun         (underrun),
    .underrun_cnt     (underrun_cnt)
  );

  dac_stream_out #(
    .DIV_N     (5),
    .PRIME_LVL (2),
    .TWOS_IN   (1)
  ) u_tc (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .enable           (tc_enable),
    .hold_on_underrun (1'b0),
    .in_data          (tc_in_data),
    .in_valid         (tc_in_valid),
    .in_ready         (tc_in_ready),
    .dac_clk          (tc_dac_clk),
    .dac_data         (tc_dac_data),
    .fifo_level       (tc_fifo_level),
    .underrun         (tc_underrun),
    .underrun_cnt     (tc_underrun_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set after this apply to the next edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_idle(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; hold_on_underrun = 1'b0; in_valid = 1'b0; in_data = '0;
    tc_enable = 1'b0; tc_in_valid = 1'b0; tc_in_data = '0;
    #2;
    check_eq("rst_dac_clk", 32'(dac_clk), 0);
    check_eq("rst_dac_data", 32'(dac_data), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_level", 32'(fifo_level), 0);
    check_eq("rst_underrun", 32'(underrun), 0);
    check_eq("rst_ucnt", 32'(underrun_cnt), 0);
    step();
    rst_n = 1'b1;
    step();

    // Prime gate: 7 samples are not enough.
    push_idle(8'h10, 7);
    enable = 1'b1;
    step(); step(); step();
    check_eq("prime_clk_low", 32'(dac_clk), 0);
    check_eq("prime_data_zero", 32'(dac_data), 0);
    check_eq("prime_level7", 32'(fifo_level), 7);
    in_valid = 1'b1; in_data = 8'h17;
    step();
    in_valid = 1'b0;
    check_eq("prime_level8", 32'(fifo_level), 8);
    check_eq("prime_still_zero", 32'(dac_data), 0);
    step();
    for (int k = 0; k < 8; k++) begin
      check_eq("stream_data", 32'(dac_data), 32'h10 + k);
      check_eq("stream_clk_lo", 32'(dac_clk), 0);
      check_eq("stream_no_ur", 32'(underrun), 0);
      step();
      check_eq("stream_clk_hi", 32'(dac_clk), 1);
      check_eq("stream_hold", 32'(dac_data), 32'h10 + k);
      if (k < 7) step();
    end
    enable = 1'b0;
    step();
    check_eq("dis1_data", 32'(dac_data), 32'h80);
    check_eq("dis1_level", 32'(fifo_level), 0);

    // Underrun with hold, then midscale.
    hold_on_underrun = 1'b1;
    push_idle(8'h30, 8);
    enable = 1'b1;
    step(); step();
    for (int k = 0; k < 8; k++) begin
      check_eq("ur_play", 32'(dac_data), 32'h30 + k);
      step(); step();
    end
    for (int m = 0; m < 5; m++) begin
      check_eq("ur_pulse", 32'(underrun), 1);
      check_eq("ur_cnt", 32'(underrun_cnt), m + 1);
      check_eq("ur_hold_data", 32'(dac_data), 32'h37);
      step();
      check_eq("ur_pulse_end", 32'(underrun), 0);
      if (m == 4) hold_on_underrun = 1'b0;
      step();
    end
    check_eq("ur_mid_data", 32'(dac_data), 32'h80);
    check_eq("ur_cnt6", 32'(underrun_cnt), 6);
    step();
    in_valid = 1'b1; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    check_eq("push_on_tick_ur", 32'(underrun), 1);
    check_eq("push_on_tick_data", 32'(dac_data), 32'h80);
    check_eq("push_on_tick_lvl", 32'(fifo_level), 1);
    step(); step();
    check_eq("late_sample", 32'(dac_data), 32'h55);
    check_eq("late_no_ur", 32'(underrun), 0);
    check_eq("late_cnt7", 32'(underrun_cnt), 7);
    enable = 1'b0;
    step();

    // Full FIFO.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(i);
      if (in_ready) acc++;
      step();
      if (i == 14) check_eq("full_ready_at15", 32'(in_ready), 1);
      if (i == 15) check_eq("full_ready_low", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    check_eq("full_accepted", acc, 16);
    check_eq("full_level", 32'(fifo_level), 16);
    enable = 1'b1;
    step(); step();
    check_eq("full_first", 32'(dac_data), 32'h60);
    check_eq("full_lvl15", 32'(fifo_level), 15);
    for (int j = 0; j < 3; j++) begin
      step();
      in_valid = 1'b1; in_data = 8'h70 + 8'(j);
      step();
      in_valid = 1'b0;
      check_eq("pushpop_data", 32'(dac_data), 32'h61 + j);
      check_eq("pushpop_level", 32'(fifo_level), 15);
    end
    for (int j = 0; j < 5; j++) begin
      step(); step();
      check_eq("drain_data", 32'(dac_data), 32'h64 + j);
    end
    check_eq("drain_lvl10", 32'(fifo_level), 10);
    enable = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    step();
    in_valid = 1'b0;
    check_eq("dis2_level", 32'(fifo_level), 0);
    check_eq("dis2_data", 32'(dac_data), 32'h80);
    check_eq("dis2_clk", 32'(dac_clk), 0);
    step();
    check_eq("dis2_discard", 32'(fifo_level), 0);

    // Asynchronous reset mid-sample.
    push_idle(8'hA0, 8);
    enable = 1'b1;
    step(); step(); step();
    check_eq("pre_rst_clk", 32'(dac_clk), 1);
    check_eq("pre_rst_data", 32'(dac_data), 32'hA0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_clk", 32'(dac_clk), 0);
    check_eq("arst_data", 32'(dac_data), 0);
    check_eq("arst_level", 32'(fifo_level), 0);
    check_eq("arst_ready", 32'(in_ready), 1);
    check_eq("arst_ucnt", 32'(underrun_cnt), 0);
    enable = 1'b0;
    #2 rst_n = 1'b1;
    step();

    // Two's-complement input, DIV_N = 5.
    tc_in_valid = 1'b1; tc_in_data = 8'h80;
    step();
    tc_in_data = 8'h7F;
    step();
    tc_in_valid = 1'b0;
    tc_enable = 1'b1;
    step(); step();
    for (int c = 0; c < 5; c++) begin
      check_eq("tc_data_00", 32'(tc_dac_data), 32'h00);
      check_eq("tc_clk_phase", 32'(tc_dac_clk), (c >= 2) ? 1 : 0);
      step();
    end
    check_eq("tc_data_ff", 32'(tc_dac_data), 32'hFF);
    check_eq("tc_clk_fall", 32'(tc_dac_clk), 0);
    tc_enable = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
